// File: rtl/mem_model_hs_if.sv
// rtl/mem_model_hs_if.sv - request/response handshake bundle for mem_model_hs
interface mem_model_hs_if #(
    parameter int ADDR_WID = 9,
    parameter int DATA_WID = 64
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_WID-1:0]     req_addr;
    logic [DATA_WID-1:0]     req_wdata;
    logic [DATA_WID/8-1:0]   req_wmask;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WID-1:0]     rsp_rdata;
    logic                    rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_model_hs.sv
// rtl/mem_model_hs.sv - single-outstanding byte-masked memory model with fixed response latency
// Optional MEM_ADDR_CHECK_EN: flag out-of-range requests on rsp_err.
module mem_model_hs #(
    parameter int DATA_DEP = 512,
    parameter int ADDR_WID = 9,
    parameter int DATA_WID = 64,
    parameter int LATENCY  = 1
) (
    input  logic           clk,
    input  logic           nrst,
    mem_model_hs_if.slave  bus
);
    localparam int NBYTE = DATA_WID / 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WID-1:0]   mem [DATA_DEP];
    logic [DATA_WID-1:0]   rdata_q;
    logic                  accept;
    logic                  in_range;

    assign in_range = ({1'b0, bus.req_addr} < (ADDR_WID+1)'(DATA_DEP));
    assign accept   = bus.req_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory is deliberately outside the reset domain so contents survive nrst.
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && in_range) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (bus.req_wmask[b]) mem[bus.req_addr][8*b +: 8] <= bus.req_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= (!bus.req_we && in_range) ? mem[bus.req_addr] : '0;
        end
    end

    assign bus.rsp_rdata = rdata_q;

`ifdef MEM_ADDR_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       err_q <= 1'b0;
        else if (accept) err_q <= !in_range;
    end

    assign bus.rsp_err = err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_model_hs.sv
// tb/tb_mem_model_hs.sv - randomized self-checking bench for mem_model_hs (LATENCY 0 and 3 instances)
module tb_mem_model_hs;
    localparam int DEP = 300;
    localparam int AW  = 9;
    localparam int DW  = 64;
    localparam int MW  = DW / 8;
`ifdef MEM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif
    localparam int LAT [2] = '{0, 3};

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [AW-1:0] req_addr  = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [MW-1:0] req_wmask = '0;
    logic          req_ready_m, rsp_valid_m, rsp_err_m;
    logic [DW-1:0] rsp_rdata_m;
    logic [DW-1:0] ref_mem [2][DEP];

    mem_model_hs_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus0 ();
    mem_model_hs_if #(.ADDR_WID(AW), .DATA_WID(DW)) bus3 ();

    mem_model_hs #(.DATA_DEP(DEP), .ADDR_WID(AW), .DATA_WID(DW), .LATENCY(0)) u_dut0 (
        .clk(clk), .nrst(nrst), .bus(bus0.slave));
    mem_model_hs #(.DATA_DEP(DEP), .ADDR_WID(AW), .DATA_WID(DW), .LATENCY(3)) u_dut3 (
        .clk(clk), .nrst(nrst), .bus(bus3.slave));

    assign bus0.req_valid = req_valid && (sel == 0);
    assign bus3.req_valid = req_valid && (sel == 1);
    assign bus0.rsp_ready = rsp_ready && (sel == 0);
    assign bus3.rsp_ready = rsp_ready && (sel == 1);
    assign bus0.req_we    = req_we;
    assign bus3.req_we    = req_we;
    assign bus0.req_addr  = req_addr;
    assign bus3.req_addr  = req_addr;
    assign bus0.req_wdata = req_wdata;
    assign bus3.req_wdata = req_wdata;
    assign bus0.req_wmask = req_wmask;
    assign bus3.req_wmask = req_wmask;

    assign req_ready_m = (sel == 1) ? bus3.req_ready : bus0.req_ready;
    assign rsp_valid_m = (sel == 1) ? bus3.rsp_valid : bus0.rsp_valid;
    assign rsp_rdata_m = (sel == 1) ? bus3.rsp_rdata : bus0.rsp_rdata;
    assign rsp_err_m   = (sel == 1) ? bus3.rsp_err   : bus0.rsp_err;

    // Reference: a plain word array per instance; out-of-range never touches it.
    task automatic model_apply(input int s, input bit we, input int unsigned addr,
                               input logic [DW-1:0] wdata, input logic [MW-1:0] mask,
                               output logic [DW-1:0] er, output logic ee);
        ee = CHECK_EN && (addr >= DEP);
        er = '0;
        if (addr < DEP) begin
            if (we) begin
                for (int b = 0; b < MW; b++)
                    if (mask[b]) ref_mem[s][addr][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                er = ref_mem[s][addr];
            end
        end
    endtask

    task automatic issue(input bit we, input int unsigned addr, input logic [DW-1:0] wdata,
                         input logic [MW-1:0] mask, output bit ok);
        req_we = we; req_addr = addr[AW-1:0]; req_wdata = wdata; req_wmask = mask;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready_m) ok = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    task automatic finish_rsp(input int hold, input bit scramble, output logic [DW-1:0] rdata,
                              output logic err, output int lat, output bit quiet, output bit ok);
        int n;
        n = 0; lat = 1; quiet = 1'b1; ok = 1'b0; rdata = '0; err = 1'b0;
        while (!rsp_valid_m && n < 40) begin
            if (req_ready_m) quiet = 1'b0;
            if (scramble) begin
                req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = AW'($urandom);
            end
            @(negedge clk);
            lat++; n++;
        end
        if (!rsp_valid_m) begin
            req_valid = 1'b0;
            return;
        end
        ok = 1'b1; rdata = rsp_rdata_m; err = rsp_err_m;
        for (int h = 0; h < hold; h++) begin
            if (scramble) begin
                req_valid = 1'($urandom); req_wdata = {$urandom, $urandom};
            end
            @(negedge clk);
            if (!rsp_valid_m || req_ready_m || rsp_rdata_m !== rdata || rsp_err_m !== err) quiet = 1'b0;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic xfer(input bit we, input int unsigned addr, input logic [DW-1:0] wdata,
                        input logic [MW-1:0] mask, input int hold, input bit scramble,
                        output logic [DW-1:0] rdata, output logic err, output int lat,
                        output bit quiet, output bit ok);
        issue(we, addr, wdata, mask, ok);
        if (!ok) return;
        finish_rsp(hold, scramble, rdata, err, lat, quiet, ok);
    endtask

    task automatic test_reset;
        #1 nrst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            checks++; if (rsp_valid_m !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid dut=%0d got=%b exp=0", s, rsp_valid_m); end
            checks++; if (rsp_rdata_m !== '0) begin failures++; $display("FAIL reset_rdata dut=%0d got=%h exp=0", s, rsp_rdata_m); end
            checks++; if (rsp_err_m !== 1'b0) begin failures++; $display("FAIL reset_err dut=%0d got=%b exp=0", s, rsp_err_m); end
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s; #1;
            checks++; if (req_ready_m !== 1'b1) begin failures++; $display("FAIL reset_req_ready dut=%0d got=%b exp=1", s, req_ready_m); end
        end
        @(negedge clk);
    endtask

    task automatic test_preload;
        logic [DW-1:0] rd, er, wd; logic ee, e; int lat; bit q, ok, all_ok;
        all_ok = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int a = 0; a < DEP; a++) begin
                wd = {$urandom, $urandom};
                xfer(1'b1, a, wd, 8'hFF, 0, 1'b0, rd, e, lat, q, ok);
                model_apply(s, 1'b1, a, wd, 8'hFF, er, ee);
                if (!ok) all_ok = 1'b0;
            end
        end
        checks++; if (!all_ok) begin failures++; $display("FAIL preload_handshake got=timeout exp=complete"); end
    endtask

    task automatic test_lat0_basic;
        logic [DW-1:0] rd, er; logic e, ee; int lat; bit q, ok;
        sel = 0;
        xfer(1'b1, 5, 64'h1122334455667788, 8'hFF, 0, 1'b0, rd, e, lat, q, ok);
        model_apply(0, 1'b1, 5, 64'h1122334455667788, 8'hFF, er, ee);
        checks++; if (!ok || lat != 1) begin failures++; $display("FAIL lat0_write_latency got=%0d ok=%b exp=1", lat, ok); end
        checks++; if (rd !== 64'h0) begin failures++; $display("FAIL lat0_write_rdata got=%h exp=0", rd); end
        xfer(1'b0, 5, '0, '0, 0, 1'b0, rd, e, lat, q, ok);
        checks++; if (!ok || lat != 1) begin failures++; $display("FAIL lat0_read_latency got=%0d ok=%b exp=1", lat, ok); end
        checks++; if (rd !== 64'h1122334455667788) begin failures++; $display("FAIL lat0_read_rdata got=%h exp=1122334455667788", rd); end
        checks++; if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0) begin failures++; $display("FAIL lat0_idle got=ready%b valid%b exp=ready1 valid0", req_ready_m, rsp_valid_m); end
    endtask

    task automatic test_partial_mask;
        logic [DW-1:0] rd, er; logic e, ee; int lat; bit q, ok;
        sel = 0;
        xfer(1'b1, 7, {DW{1'b1}}, 8'hFF, 0, 1'b0, rd, e, lat, q, ok);
        model_apply(0, 1'b1, 7, {DW{1'b1}}, 8'hFF, er, ee);
        xfer(1'b1, 7, 64'h0, 8'h0F, 1, 1'b0, rd, e, lat, q, ok);
        model_apply(0, 1'b1, 7, 64'h0, 8'h0F, er, ee);
        xfer(1'b0, 7, '0, '0, 0, 1'b0, rd, e, lat, q, ok);
        checks++; if (!ok || rd !== 64'hFFFFFFFF00000000) begin failures++; $display("FAIL partial_mask got=%h exp=ffffffff00000000", rd); end
        xfer(1'b1, 7, 64'h0123456789ABCDEF, 8'h00, 0, 1'b0, rd, e, lat, q, ok);
        checks++; if (!ok || rd !== 64'h0) begin failures++; $display("FAIL zero_mask_rsp got=%h ok=%b exp=0", rd, ok); end
        xfer(1'b0, 7, '0, '0, 0, 1'b0, rd, e, lat, q, ok);
        checks++; if (rd !== 64'hFFFFFFFF00000000) begin failures++; $display("FAIL zero_mask_noop got=%h exp=ffffffff00000000", rd); end
    endtask

    task automatic test_latency_hold;
        logic [DW-1:0] rd, er; logic e, ee; int lat; bit q, ok;
        sel = 1;
        model_apply(1, 1'b0, 20, '0, '0, er, ee);
        xfer(1'b0, 20, '0, '0, 4, 1'b0, rd, e, lat, q, ok);
        checks++; if (!ok || lat != 4) begin failures++; $display("FAIL lat3_latency got=%0d ok=%b exp=4", lat, ok); end
        checks++; if (rd !== er) begin failures++; $display("FAIL lat3_rdata got=%h exp=%h", rd, er); end
        checks++; if (!q) begin failures++; $display("FAIL lat3_stable got=unstable exp=stable"); end
        checks++; if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0) begin failures++; $display("FAIL lat3_idle got=ready%b valid%b exp=ready1 valid0", req_ready_m, rsp_valid_m); end
    endtask

    task automatic test_out_of_range;
        logic [DW-1:0] rd, er, wd; logic e, ee; int lat; bit q, ok;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            wd = {$urandom, $urandom};
            xfer(1'b1, 400, wd, 8'hFF, 0, 1'b0, rd, e, lat, q, ok);
            model_apply(s, 1'b1, 400, wd, 8'hFF, er, ee);
            checks++; if (!ok || e !== ee || rd !== '0) begin failures++; $display("FAIL oor_write dut=%0d got=err%b rd=%h exp=err%b rd=0", s, e, rd, ee); end
            xfer(1'b0, 400, '0, '0, 0, 1'b0, rd, e, lat, q, ok);
            checks++; if (!ok || e !== ee || rd !== '0) begin failures++; $display("FAIL oor_read dut=%0d got=err%b rd=%h exp=err%b rd=0", s, e, rd, ee); end
            checks++; if (lat != LAT[s] + 1) begin failures++; $display("FAIL oor_latency dut=%0d got=%0d exp=%0d", s, lat, LAT[s] + 1); end
            model_apply(s, 1'b0, 144, '0, '0, er, ee);
            xfer(1'b0, 144, '0, '0, 0, 1'b0, rd, e, lat, q, ok);
            checks++; if (rd !== er || e !== 1'b0) begin failures++; $display("FAIL oor_alias dut=%0d got=%h exp=%h", s, rd, er); end
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] rd, er, wd; logic e, ee; logic [MW-1:0] m; int lat; bit q, ok, we;
        int unsigned a;
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 1));
            we = 1'($urandom); a = $urandom_range(0, 349);
            wd = {$urandom, $urandom}; m = MW'($urandom);
            xfer(we, a, wd, m, int'($urandom_range(0, 3)), 1'b1, rd, e, lat, q, ok);
            model_apply(sel, we, a, wd, m, er, ee);
            checks++; if (!ok || rd !== er || e !== ee) begin failures++; $display("FAIL rand_data i=%0d dut=%0d we=%b a=%0d got=%h/%b exp=%h/%b", i, sel, we, a, rd, e, er, ee); end
            checks++; if (lat != LAT[sel] + 1 || !q) begin failures++; $display("FAIL rand_timing i=%0d dut=%0d got=lat%0d quiet%b exp=lat%0d quiet1", i, sel, lat, q, LAT[sel] + 1); end
        end
    endtask

    task automatic test_back_to_back;
        int cnt, n;
        for (int s = 0; s < 2; s++) begin
            sel = s; cnt = 0;
            req_we = 1'b0; req_addr = AW'(10); req_valid = 1'b1; rsp_ready = 1'b1;
            for (int c = 0; c < 8 * (LAT[s] + 2); c++) begin
                @(negedge clk);
                if (rsp_valid_m) cnt++;
            end
            req_valid = 1'b0; n = 0;
            while (!(req_ready_m && !rsp_valid_m) && n < 20) begin
                @(negedge clk); n++;
            end
            rsp_ready = 1'b0;
            checks++; if (cnt != 8) begin failures++; $display("FAIL b2b_throughput dut=%0d got=%0d exp=8", s, cnt); end
            checks++; if (n >= 20) begin failures++; $display("FAIL b2b_drain dut=%0d got=timeout exp=idle", s); end
        end
    endtask

    task automatic test_reset_in_wait;
        logic [DW-1:0] rd, er; logic e, ee; int lat; bit q, ok;
        sel = 1;
        issue(1'b1, 2, 64'hAB, 8'h01, ok);
        model_apply(1, 1'b1, 2, 64'hAB, 8'h01, er, ee);
        @(negedge clk);
        nrst = 1'b0; #1;
        checks++; if (!ok || rsp_valid_m !== 1'b0) begin failures++; $display("FAIL rst_wait_valid got=%b ok=%b exp=0", rsp_valid_m, ok); end
        @(negedge clk);
        nrst = 1'b1; #1;
        checks++; if (req_ready_m !== 1'b1 || rsp_valid_m !== 1'b0) begin failures++; $display("FAIL rst_wait_ready got=ready%b valid%b exp=ready1 valid0", req_ready_m, rsp_valid_m); end
        @(negedge clk);
        xfer(1'b0, 2, '0, '0, 0, 1'b0, rd, e, lat, q, ok);
        checks++; if (!ok || rd[7:0] !== 8'hAB) begin failures++; $display("FAIL rst_wait_commit got=%h exp=ab", rd[7:0]); end
        model_apply(1, 1'b0, 2, '0, '0, er, ee);
        checks++; if (rd !== er) begin failures++; $display("FAIL rst_wait_word got=%h exp=%h", rd, er); end
    endtask

    task automatic test_sweep;
        logic [DW-1:0] rd, er; logic e, ee; int lat; bit q, ok;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int a = 0; a < DEP; a++) begin
                xfer(1'b0, a, '0, '0, 0, 1'b0, rd, e, lat, q, ok);
                model_apply(s, 1'b0, a, '0, '0, er, ee);
                checks++; if (!ok || rd !== er) begin failures++; $display("FAIL sweep dut=%0d a=%0d got=%h exp=%h", s, a, rd, er); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_lat0_basic();
        test_partial_mask();
        test_latency_hold();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_reset_in_wait();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
